// File: rtl/frame_streamer.sv
// Frame buffer: loads one image through a valid/sop port and replays it
// as a pixel stream with sop/eop framing and column/row position counters.
module frame_streamer #(
  parameter int PIX_WIDTH  = 8,
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_en,
  input  logic [PIX_WIDTH-1:0] i_data,
  input  logic                 i_valid,
  input  logic                 i_sop,
  output logic                 i_ready,
  input  logic                 start,
  output logic [PIX_WIDTH-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_sop,
  output logic                 o_eop,
  input  logic                 o_ready,
  output logic                 frame_ready,
  output logic                 busy,
  output logic [11:0]          cols_cntr,
  output logic [11:0]          rows_cntr
);

  localparam int DEPTH = IMG_WIDTH * IMG_HEIGHT;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [AW-1:0] LAST     = AW'(DEPTH - 1);
  localparam logic [11:0]   COL_LAST = 12'(IMG_WIDTH - 1);
  localparam logic [11:0]   ROW_LAST = 12'(IMG_HEIGHT - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_LOADED = 2'd2;
  localparam logic [1:0] S_SEND   = 2'd3;

  logic [PIX_WIDTH-1:0] mem [DEPTH];

  logic [1:0]    state;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;

  logic          sop_hit;
  logic          wr_load;
  logic          we;
  logic [AW-1:0] wa;
  logic          go;
  logic          hs;
  logic          adv;
  logic          fetch;

  assign i_ready = (state != S_SEND);
  assign busy    = (state == S_LOAD) || (state == S_SEND);

  assign sop_hit = i_valid && i_sop && i_ready;
  assign wr_load = (state == S_LOAD) && i_valid;
  assign we      = sop_hit || wr_load;
  assign wa      = sop_hit ? '0 : wr_addr;
  assign go      = (state == S_LOADED) && start && !sop_hit;

  assign hs    = o_valid && o_ready;
  assign adv   = !o_valid || o_ready;
  // Read ahead while the output slot frees up; stop once eop is staged.
  assign fetch = (state == S_SEND) && adv && !(o_valid && o_eop);

  // Store is intentionally not reset; frame_ready qualifies its contents.
  always_ff @(posedge clk) begin
    if (clk_en && we) begin
      mem[wa] <= i_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      wr_addr     <= '0;
      frame_ready <= 1'b0;
    end else if (clk_en) begin
      if (sop_hit) begin
        state       <= S_LOAD;
        wr_addr     <= AW'(1);
        frame_ready <= 1'b0;
      end else begin
        unique case (state)
          S_LOAD: begin
            if (i_valid) begin
              if (wr_addr == LAST) begin
                state       <= S_LOADED;
                frame_ready <= 1'b1;
              end else begin
                wr_addr <= wr_addr + AW'(1);
              end
            end
          end
          S_LOADED: begin
            if (go) state <= S_SEND;
          end
          S_SEND: begin
            if (hs && o_eop) state <= S_LOADED;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr   <= '0;
      o_data    <= '0;
      o_valid   <= 1'b0;
      o_sop     <= 1'b0;
      o_eop     <= 1'b0;
      cols_cntr <= '0;
      rows_cntr <= '0;
    end else if (clk_en) begin
      if (go) begin
        rd_addr <= '0;
      end else if (fetch) begin
        o_data  <= mem[rd_addr];
        o_valid <= 1'b1;
        o_sop   <= (rd_addr == '0);
        o_eop   <= (rd_addr == LAST);
        if (rd_addr != LAST) rd_addr <= rd_addr + AW'(1);
      end else if (adv) begin
        o_valid <= 1'b0;
        o_sop   <= 1'b0;
        o_eop   <= 1'b0;
      end

      if (go) begin
        cols_cntr <= '0;
        rows_cntr <= '0;
      end else if (hs) begin
        if (cols_cntr == COL_LAST) begin
          cols_cntr <= '0;
          rows_cntr <= (rows_cntr == ROW_LAST) ? '0 : rows_cntr + 12'd1;
        end else begin
          cols_cntr <= cols_cntr + 12'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_streamer.sv
// Directed bench for frame_streamer on a 4x3 image: load, replay,
// backpressure, reload, ignored starts, reset abort and clock-enable freeze.
module tb_frame_streamer;

  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_en = 1'b1;
  logic [7:0]  i_data = '0;
  logic        i_valid = 1'b0;
  logic        i_sop = 1'b0;
  logic        i_ready;
  logic        start = 1'b0;
  logic [7:0]  o_data;
  logic        o_valid;
  logic        o_sop;
  logic        o_eop;
  logic        o_ready = 1'b1;
  logic        frame_ready;
  logic        busy;
  logic [11:0] cols_cntr;
  logic [11:0] rows_cntr;

  int n_vec = 0;
  int n_err = 0;

  frame_streamer #(
    .PIX_WIDTH(8),
    .IMG_WIDTH(W),
    .IMG_HEIGHT(H)
  ) dut (
    .clk(clk),
    .rst(rst),
    .clk_en(clk_en),
    .i_data(i_data),
    .i_valid(i_valid),
    .i_sop(i_sop),
    .i_ready(i_ready),
    .start(start),
    .o_data(o_data),
    .o_valid(o_valid),
    .o_sop(o_sop),
    .o_eop(o_eop),
    .o_ready(o_ready),
    .frame_ready(frame_ready),
    .busy(busy),
    .cols_cntr(cols_cntr),
    .rows_cntr(rows_cntr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int base, input int n, input bit sop_first);
    for (int i = 0; i < n; i++) begin
      i_valid = 1'b1;
      i_sop   = sop_first && (i == 0);
      i_data  = 8'(base + i);
      step();
    end
    i_valid = 1'b0;
    i_sop   = 1'b0;
  endtask

  task automatic expect_idle_out(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      step();
      chk(tag, {31'd0, o_valid}, 32'd0);
    end
  endtask

  task automatic stream(input int base, input bit toggle, input int start_at,
                        input int freeze_at, input int rst_at);
    int       k;
    int       cyc;
    bit       held;
    bit       frozen;
    logic [7:0] hold_d;
    k = 0;
    cyc = 0;
    held = 1'b0;
    frozen = 1'b0;
    hold_d = '0;
    o_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("lat1_valid", {31'd0, o_valid}, 32'd0);
    chk("send_busy", {31'd0, busy}, 32'd1);
    chk("send_iready", {31'd0, i_ready}, 32'd0);
    step();
    chk("lat2_valid", {31'd0, o_valid}, 32'd1);
    while (k < N && cyc < 200) begin
      if (k == rst_at) begin
        rst = 1'b1;
        #1;
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_eop", {31'd0, o_eop}, 32'd0);
        chk("rst_fready", {31'd0, frame_ready}, 32'd0);
        chk("rst_iready", {31'd0, i_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        step();
        rst = 1'b0;
        return;
      end
      if (k == freeze_at && !frozen) begin
        frozen = 1'b1;
        hold_d = o_data;
        clk_en = 1'b0;
        o_ready = 1'b1;
        for (int f = 0; f < 3; f++) begin
          step();
          chk("frz_data", {24'd0, o_data}, {24'd0, hold_d});
          chk("frz_valid", {31'd0, o_valid}, 32'd1);
          chk("frz_col", {20'd0, cols_cntr}, 32'(k % W));
        end
        clk_en = 1'b1;
      end
      o_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      start = (k == start_at);
      if (held) chk("hold_data", {24'd0, o_data}, {24'd0, hold_d});
      if (o_valid && o_ready) begin
        chk("data", {24'd0, o_data}, 32'((base + k) & 8'hff));
        chk("sop", {31'd0, o_sop}, {31'd0, k == 0});
        chk("eop", {31'd0, o_eop}, {31'd0, k == N - 1});
        chk("cols", {20'd0, cols_cntr}, 32'(k % W));
        chk("rows", {20'd0, rows_cntr}, 32'(k / W));
        k++;
        held = 1'b0;
      end else begin
        chk("bubble", {31'd0, o_valid}, 32'd1);
        held = 1'b1;
        hold_d = o_data;
      end
      step();
      cyc++;
    end
    start = 1'b0;
    o_ready = 1'b1;
    if (k < N) chk("stream_timeout", 32'(k), 32'(N));
    chk("end_valid", {31'd0, o_valid}, 32'd0);
    chk("end_sop_eop", {30'd0, o_sop, o_eop}, 32'd0);
    chk("end_data", {24'd0, o_data}, 32'((base + N - 1) & 8'hff));
    chk("end_fready", {31'd0, frame_ready}, 32'd1);
    chk("end_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    step();
    chk("rst_valid0", {31'd0, o_valid}, 32'd0);
    chk("rst_data0", {24'd0, o_data}, 32'd0);
    chk("rst_fready0", {31'd0, frame_ready}, 32'd0);
    chk("rst_busy0", {31'd0, busy}, 32'd0);
    chk("rst_iready0", {31'd0, i_ready}, 32'd1);
    chk("rst_pos0", {8'd0, cols_cntr, rows_cntr}, 32'd0);
    rst = 1'b0;
    step();

    start = 1'b1;
    step();
    start = 1'b0;
    chk("idle_start_busy", {31'd0, busy}, 32'd0);
    expect_idle_out("idle_start_valid", 3);

    load(0, N, 1'b1);
    chk("load_fready", {31'd0, frame_ready}, 32'd1);
    chk("load_busy", {31'd0, busy}, 32'd0);
    load(55, 1, 1'b0);
    chk("nosop_busy", {31'd0, busy}, 32'd0);
    stream(0, 1'b0, -1, -1, -1);

    stream(0, 1'b1, -1, -1, -1);

    stream(0, 1'b0, 6, -1, -1);
    stream(0, 1'b0, N - 1, -1, -1);
    expect_idle_out("eop_start_valid", 3);
    stream(0, 1'b0, -1, 4, -1);

    load(0, 6, 1'b1);
    chk("partial_fready", {31'd0, frame_ready}, 32'd0);
    chk("partial_busy", {31'd0, busy}, 32'd1);
    load(100, N - 1, 1'b1);
    chk("restart_fready", {31'd0, frame_ready}, 32'd0);
    load(100 + N - 1, 1, 1'b0);
    chk("restart_fready_end", {31'd0, frame_ready}, 32'd1);
    stream(100, 1'b0, -1, -1, -1);

    load(0, N, 1'b1);
    stream(0, 1'b0, -1, -1, 5);
    chk("post_rst_valid", {31'd0, o_valid}, 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    expect_idle_out("post_rst_start", 3);
    load(20, N, 1'b1);
    stream(20, 1'b0, -1, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/frame_streamer.md
FRAME_STREAMER -- requirements
Module: frame_streamer

Interface
REQ-001 SHALL have parameter PIX_WIDTH, default 8: pixel bit width.
REQ-002 SHALL have parameter IMG_WIDTH, default 28: pixels per row (≥2, ≤4095).
REQ-003 SHALL have parameter IMG_HEIGHT, default 28: rows per frame (≥2, ≤4095).
REQ-004 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port clk_en, input, 1: clock enable; when low, all state and outputs hold.
REQ-007 SHALL have port i_data, input, PIX_WIDTH: load pixel.
REQ-008 SHALL have port i_valid, input, 1: load pixel valid.
REQ-009 SHALL have port i_sop, input, 1: first pixel of the load frame; qualified by i_valid.
REQ-010 SHALL have port i_ready, output, 1: load side may accept a pixel.
REQ-011 SHALL have port start, input, 1: request transmission of the stored frame.
REQ-012 SHALL have port o_data, output, PIX_WIDTH: stream pixel.
REQ-013 SHALL have port o_valid, output, 1: stream pixel valid.
REQ-014 SHALL have port o_sop, output, 1: first pixel of the frame.
REQ-015 SHALL have port o_eop, output, 1: last pixel of the frame.
REQ-016 SHALL have port o_ready, input, 1: downstream accepts the current pixel.
REQ-017 SHALL have port frame_ready, output, 1: a complete frame is stored.
REQ-018 SHALL have port busy, output, 1: high in LOAD or SEND.
REQ-019 SHALL have ports cols_cntr and rows_cntr, output, 12 each: position of the current o_data pixel.

Function
REQ-020 SHALL use states IDLE, LOAD, LOADED and SEND, with an internal store of IMG_WIDTH*IMG_HEIGHT pixels.
REQ-021 SHALL advance no state when clk_en=0.
REQ-022 SHALL drive i_ready=1 in IDLE, LOAD and LOADED, and i_ready=0 in SEND.
REQ-023 SHALL, on i_valid && i_sop && i_ready, write the pixel to address 0, set the write address to 1, clear frame_ready, and enter LOAD. This applies from any non-SEND state, including mid-LOAD, where it restarts the load.
REQ-024 SHALL, in IDLE and LOADED, ignore i_valid pixels without i_sop.
REQ-025 SHALL, in LOAD, write each i_valid pixel to the next address.
REQ-026 SHALL, on the write to address IMG_WIDTH*IMG_HEIGHT-1, set frame_ready=1 and enter LOADED.
REQ-027 SHALL not change state on start in LOAD, IDLE or SEND.
REQ-028 SHALL, on start in LOADED, enter SEND with read address 0.
REQ-029 SHALL present the first o_valid exactly 2 cycles after the start cycle (1 cycle address register, 1 cycle registered memory read).
REQ-030 SHALL count a stream handshake as o_valid && o_ready.
REQ-031 SHALL, when o_valid=1 && o_ready=0, hold o_data, o_sop, o_eop, o_valid and the counters stable.
REQ-032 SHALL, after a handshake, present the next pixel on the following cycle with no bubble while o_ready stays high (full throughput, read-ahead).
REQ-033 SHALL assert o_sop only with the pixel at address 0, and o_eop only with the pixel at address IMG_WIDTH*IMG_HEIGHT-1.
REQ-034 SHALL reset cols_cntr to 0 at the start of each frame and increment it on each handshake, wrapping from IMG_WIDTH-1 to 0.
REQ-035 SHALL increment rows_cntr on each cols_cntr wrap, and reset it to 0 at the start of each frame.
REQ-036 SHALL, on the o_eop handshake, deassert o_valid on the next cycle and return to LOADED with frame_ready=1. The frame is retained, so start replays it identically.
REQ-037 SHALL, when start is asserted in the same cycle as the o_eop handshake, ignore it (state is SEND). A new start is required in LOADED.
REQ-038 SHALL keep o_sop and o_eop low whenever o_valid is low.
REQ-039 SHALL keep o_data at its last value whenever o_valid is low.

Reset
REQ-040 SHALL, while rst=1 (asynchronously), set state IDLE, clear the read and write addresses, and drive o_valid=0, o_sop=0, o_eop=0, o_data=0, frame_ready=0, busy=0, cols_cntr=0 and rows_cntr=0.
REQ-041 SHALL drive i_ready=1 after reset.
REQ-042 SHALL not reset the pixel store contents; frame_ready=0 marks them invalid.
REQ-043 SHALL, on reset mid-SEND, drop o_valid immediately, with no o_eop.

Verification (IMG_WIDTH=4, IMG_HEIGHT=3, PIX_WIDTH=8)
REQ-044 SHALL cover: load 0..11 with i_sop on 0, o_ready=1, start -> o_valid 2 cycles later; o_data 0..11 on 12 consecutive cycles; o_sop on 0; o_eop on 11; (cols,rows) (3,2) at eop; frame_ready=1 after.
REQ-045 SHALL cover: same load, o_ready toggling 1,0,1,0 -> each pixel held while o_ready=0; 12 handshakes total; no duplicate or skipped pixels.
REQ-046 SHALL cover: load pixels 0..5, then i_sop with value 100 followed by 101..111 -> frame_ready rises only after 111; stream yields 100..111.
REQ-047 SHALL cover: start in IDLE, and start during SEND -> ignored; o_valid stays 0 / the stream is unaffected; a second start in LOADED replays 0..11.
REQ-048 SHALL cover: rst pulse after the 5th handshake -> o_valid=0 same cycle; frame_ready=0; i_ready=1; start then ignored until a new full load.
REQ-049 SHALL cover: clk_en=0 for 3 cycles mid-stream with o_ready=1 -> outputs frozen; the stream resumes with the next pixel, with none lost.
